// File: rtl/panel_mem_seq_pkg.sv
// Shared types for the front-panel memory sequencer: FSM state encoding,
// the decoded panel operation and the priority encoder that picks one
// operation out of the simultaneous debounced pulses.
package panel_mem_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_CLEAR = 3'd1,
        OP_EXTD  = 3'd2,
        OP_LOAD  = 3'd3,
        OP_DEP   = 3'd4,
        OP_EXAM  = 3'd5
    } op_t;

    localparam int ACK_TIMEOUT_DEFAULT = 16;

    // Fixed priority: CLEAR > EXTD ADDR > LOAD ADDR > DEP > EXAM.
    // Anything below the winner in the same cycle is simply dropped.
    function automatic op_t select_op(
        input logic clr,
        input logic extd,
        input logic load,
        input logic dep,
        input logic exam
    );
        op_t op;
        op = OP_NONE;
        if (clr)       op = OP_CLEAR;
        else if (extd) op = OP_EXTD;
        else if (load) op = OP_LOAD;
        else if (dep)  op = OP_DEP;
        else if (exam) op = OP_EXAM;
        return op;
    endfunction

endpackage

// File: rtl/panel_mem_seq.sv
// Front-panel memory sequencer for the PDP-8e core. While the CPU is halted
// it turns single-cycle panel pulses into register loads (LOAD ADDR, EXTD
// ADDR), a CLEAR pulse, or one memory transaction (DEP = write, EXAM = read).
//
// Memory handshake: mem_req is raised by the accept edge and held with
// mem_addr/mem_we/mem_wdata frozen until the first cycle mem_ack=1 (the
// transfer completes on that edge) or until ACK_TIMEOUT unacknowledged
// cycles have elapsed (the request is abandoned and mem_err is set).
// mem_ack seen while no request is outstanding is ignored.
module panel_mem_seq
    import panel_mem_seq_pkg::*;
#(
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [0:11]  sr,
    input  logic         addr_loadd,
    input  logic         extd_addrd,
    input  logic         depd,
    input  logic         examd,
    input  logic         cleard,
    input  logic         run,
    input  logic [0:11]  mem_rdata,
    input  logic         mem_ack,
    output logic         mem_req,
    output logic         mem_we,
    output logic [0:14]  mem_addr,
    output logic [0:11]  mem_wdata,
    output logic [0:11]  pc,
    output logic [0:2]   ifr,
    output logic [0:2]   dfr,
    output logic [0:11]  mb,
    output logic         clear_req,
    output logic         busy,
    output logic         mem_err,
    output state_t       o_dbg_state
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    // Abort fires on the edge where the count would reach ACK_TIMEOUT,
    // so mem_req stays high for exactly ACK_TIMEOUT cycles.
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    state_t         r_state;
    state_t         w_next_state;
    op_t            w_op;
    logic           w_ack_done;
    logic           w_timeout;

    logic [0:11]    r_pc;
    logic [0:2]     r_ifr;
    logic [0:2]     r_dfr;
    logic [0:11]    r_mb;
    logic [0:11]    r_mem_wdata;
    logic [0:14]    r_mem_addr;
    logic           r_mem_req;
    logic           r_mem_we;
    logic           r_clear_req;
    logic           r_mem_err;
    logic [CW-1:0]  r_cnt;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: accept one operation in IDLE when halted; leave WRITE/READ on ack or timeout.
    always_comb begin
        w_op         = OP_NONE;
        w_ack_done   = 1'b0;
        w_timeout    = 1'b0;
        w_next_state = r_state;
        if (r_state == ST_IDLE && !run) begin
            w_op = select_op(cleard, extd_addrd, addr_loadd, depd, examd);
        end
        if (r_state != ST_IDLE) begin
            w_ack_done = mem_ack;
            w_timeout  = !mem_ack && (r_cnt == CNT_LAST);
        end
        case (r_state)
            ST_IDLE: begin
                if (w_op == OP_DEP) begin
                    w_next_state = ST_WRITE;
                end else if (w_op == OP_EXAM) begin
                    w_next_state = ST_READ;
                end
            end
            ST_WRITE, ST_READ: begin
                if (w_ack_done || w_timeout) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Outputs derived directly from the state.
    always_comb begin
        busy        = (r_state != ST_IDLE);
        o_dbg_state = r_state;
    end

    // Panel registers and the registered memory request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc        <= '0;
            r_ifr       <= '0;
            r_dfr       <= '0;
            r_mb        <= '0;
            r_mem_wdata <= '0;
            r_mem_addr  <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_clear_req <= 1'b0;
            r_mem_err   <= 1'b0;
        end else begin
            r_clear_req <= 1'b0;
            case (w_op)
                OP_CLEAR: r_clear_req <= 1'b1;
                OP_EXTD: begin
                    r_ifr <= sr[6:8];
                    r_dfr <= sr[9:11];
                end
                OP_LOAD: r_pc <= sr;
                OP_DEP: begin
                    r_mem_wdata <= sr;
                    r_mem_addr  <= {r_ifr, r_pc};
                    r_mem_we    <= 1'b1;
                    r_mem_req   <= 1'b1;
                    r_mem_err   <= 1'b0;
                end
                OP_EXAM: begin
                    r_mem_addr  <= {r_ifr, r_pc};
                    r_mem_we    <= 1'b0;
                    r_mem_req   <= 1'b1;
                    r_mem_err   <= 1'b0;
                end
                default: ;
            endcase
            // Completion: pc advances within the current field only.
            if (w_ack_done) begin
                r_mem_req <= 1'b0;
                r_pc      <= r_pc + 12'd1;
                r_mb      <= (r_state == ST_WRITE) ? r_mem_wdata : mem_rdata;
            end else if (w_timeout) begin
                r_mem_req <= 1'b0;
                r_mem_err <= 1'b1;
            end
        end
    end

    // Counts unacknowledged request cycles; idle or completing clears it.
    always_ff @(posedge clk) begin
        if (reset || r_state == ST_IDLE) begin
            r_cnt <= '0;
        end else if (!mem_ack && !w_timeout) begin
            r_cnt <= r_cnt + CW'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign pc        = r_pc;
    assign ifr       = r_ifr;
    assign dfr       = r_dfr;
    assign mb        = r_mb;
    assign clear_req = r_clear_req;
    assign mem_err   = r_mem_err;

endmodule

// File: tb/tb_panel_mem_seq.sv
// Bench for panel_mem_seq: directed panel sequences, a small memory model
// that acks after a programmable wait, and a scoreboard that checks a
// snapshot of the panel state whenever a transaction ends or CLEAR fires.
module tb_panel_mem_seq;
    import panel_mem_seq_pkg::*;

    localparam int W = 60;
    localparam int M_CLR  = 1;
    localparam int M_EXTD = 2;
    localparam int M_LOAD = 4;
    localparam int M_DEP  = 8;
    localparam int M_EXAM = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [0:11]  sr;
    logic         addr_loadd, extd_addrd, depd, examd, cleard, run;
    logic [0:11]  mem_rdata;
    logic         mem_ack;
    logic         mem_req, mem_we;
    logic [0:14]  mem_addr;
    logic [0:11]  mem_wdata, pc, mb;
    logic [0:2]   ifr, dfr;
    logic         clear_req, busy, mem_err;
    state_t       dbg_state;

    logic         model_ack = 1'b0;
    logic         force_ack = 1'b0;
    logic         ack_en = 1'b1;
    int           ack_wait = 0;
    int           wait_cnt = 0;
    logic [11:0]  rd_val = 12'o0;
    int           write_count = 0;

    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;
    logic         prev_busy = 1'b0;

    assign mem_ack   = model_ack | force_ack;
    assign mem_rdata = rd_val;

    panel_mem_seq #(.ACK_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .sr(sr),
        .addr_loadd(addr_loadd), .extd_addrd(extd_addrd), .depd(depd),
        .examd(examd), .cleard(cleard), .run(run),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .pc(pc), .ifr(ifr), .dfr(dfr), .mb(mb),
        .clear_req(clear_req), .busy(busy), .mem_err(mem_err),
        .o_dbg_state(dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    // Memory model: acks the ack_wait-th cycle of an outstanding request.
    always begin
        @(posedge clk);
        #1;
        if (mem_req && ack_en) begin
            model_ack = (wait_cnt == ack_wait);
            wait_cnt++;
        end else begin
            model_ack = 1'b0;
            wait_cnt  = 0;
        end
    end

    // Count completed writes seen on the bus.
    always @(negedge clk) begin
        if (mem_req && mem_ack && mem_we) write_count++;
    end

    function automatic logic [W-1:0] rec(input logic tag, input logic [14:0] a,
                                         input logic we, input logic [11:0] wd,
                                         input logic [11:0] p, input logic [2:0] i,
                                         input logic [2:0] d, input logic [11:0] m,
                                         input logic err);
        return {tag, a, we, wd, p, i, d, m, err};
    endfunction

    task automatic sb_compare(input logic [W-1:0] got, input string name);
        logic [W-1:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event, got %h with nothing expected", name, got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", name, got, exp);
            end
        end
    endtask

    // Monitor: snapshot on CLEAR pulse and at the end of every transaction.
    always @(negedge clk) begin
        if (clear_req === 1'b1)
            sb_compare(rec(1'b1, mem_addr, mem_we, mem_wdata, pc, ifr, dfr, mb, mem_err), "clear_evt");
        if (prev_busy && !busy)
            sb_compare(rec(1'b0, mem_addr, mem_we, mem_wdata, pc, ifr, dfr, mb, mem_err), "txn_end");
        prev_busy = busy;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0o expected %0o", name, got, exp);
        end
    endtask

    // Drive one cycle of panel pulses; returns just after the accept edge.
    task automatic pulse(input int mask, input logic [11:0] v);
        @(posedge clk); #1;
        sr         = v;
        cleard     = mask[0];
        extd_addrd = mask[1];
        addr_loadd = mask[2];
        depd       = mask[3];
        examd      = mask[4];
        @(posedge clk); #1;
        {cleard, extd_addrd, addr_loadd, depd, examd} = '0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s: busy still %0d after %0d cycles, required 0", name, busy, n);
        end
        @(negedge clk); #1;
    endtask

    task automatic push(input logic tag, input logic [14:0] a, input logic we,
                        input logic [11:0] wd, input logic [11:0] p, input logic [2:0] i,
                        input logic [2:0] d, input logic [11:0] m, input logic err);
        exp_q.push_back(rec(tag, a, we, wd, p, i, d, m, err));
    endtask

    initial begin
        int n;
        int wc0;
        reset = 1'b1;
        sr = '0;
        {cleard, extd_addrd, addr_loadd, depd, examd, run} = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        // Reset state.
        check("rst_pc", 32'(pc), 32'o0);
        check("rst_fields", 32'({ifr, dfr}), 32'o0);
        check("rst_mb", 32'(mb), 32'o0);
        check("rst_ctrl", 32'({mem_req, mem_we, clear_req, busy, mem_err}), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'o0);

        // 1: LOAD ADDR 0200, DEP 1234 with zero-wait memory.
        pulse(M_LOAD, 12'o0200);
        check("load_pc", 32'(pc), 32'o0200);
        push(1'b0, 15'o00200, 1'b1, 12'o1234, 12'o0201, 3'o0, 3'o0, 12'o1234, 1'b0);
        pulse(M_DEP, 12'o1234);
        check("dep_req_hi", 32'(mem_req), 32'd1);
        wait_idle("dep1");

        // 2: EXTD ADDR splits sr[6:8] -> IF and sr[9:11] -> DF.
        pulse(M_EXTD, 12'o0030);
        check("extd_0030", 32'({ifr, dfr}), 32'o30);
        pulse(M_EXTD, 12'o0003);
        check("extd_0003", 32'({ifr, dfr}), 32'o03);
        pulse(M_EXTD, 12'o0070);
        check("extd_0070", 32'({ifr, dfr}), 32'o70);
        pulse(M_LOAD, 12'o7777);
        rd_val = 12'o4321;
        push(1'b0, 15'o77777, 1'b0, 12'o1234, 12'o0000, 3'o7, 3'o0, 12'o4321, 1'b0);
        pulse(M_EXAM, 12'o0000);
        wait_idle("exam_wrap");

        // 3: DEP wins over EXAM; CLEAR wins over LOAD ADDR.
        pulse(M_LOAD, 12'o0100);
        wc0 = write_count;
        push(1'b0, 15'o70100, 1'b1, 12'o5555, 12'o0101, 3'o7, 3'o0, 12'o5555, 1'b0);
        pulse(M_DEP | M_EXAM, 12'o5555);
        wait_idle("dep_exam");
        check("dep_exam_writes", 32'(write_count - wc0), 32'd1);
        push(1'b1, 15'o70100, 1'b1, 12'o5555, 12'o0101, 3'o7, 3'o0, 12'o5555, 1'b0);
        pulse(M_CLR | M_LOAD, 12'o2222);
        @(negedge clk); #1;
        check("clr_pc_kept", 32'(pc), 32'o0101);

        // 4: EXAM with no ack times out after 16 request cycles.
        ack_en = 1'b0;
        push(1'b0, 15'o70101, 1'b0, 12'o5555, 12'o0101, 3'o7, 3'o0, 12'o5555, 1'b1);
        pulse(M_EXAM, 12'o0000);
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        check("timeout_cycles", 32'(n), 32'd16);
        wait_idle("timeout");
        check("timeout_err", 32'(mem_err), 32'd1);
        ack_en = 1'b1;
        push(1'b0, 15'o70101, 1'b1, 12'o0007, 12'o0102, 3'o7, 3'o0, 12'o0007, 1'b0);
        pulse(M_DEP, 12'o0007);
        wait_idle("dep_after_to");

        // 5: everything ignored while running.
        run = 1'b1;
        for (int k = 0; k < 5; k++) begin
            pulse(1 << k, 12'o7777);
            check("run_no_req", 32'({mem_req, busy}), 32'd0);
        end
        pulse(M_CLR | M_EXTD | M_LOAD | M_DEP | M_EXAM, 12'o7777);
        @(negedge clk); #1;
        check("run_pc", 32'(pc), 32'o0102);
        check("run_fields", 32'({ifr, dfr}), 32'o70);
        check("run_mb", 32'(mb), 32'o0007);
        run = 1'b0;

        // Pulses during a slow write are dropped: one write only.
        ack_wait = 2;
        wc0 = write_count;
        push(1'b0, 15'o70102, 1'b1, 12'o0011, 12'o0103, 3'o7, 3'o0, 12'o0011, 1'b0);
        pulse(M_DEP, 12'o0011);
        pulse(M_DEP | M_EXAM, 12'o0022);
        wait_idle("slow_dep");
        check("slow_dep_writes", 32'(write_count - wc0), 32'd1);

        // run rising mid-transaction does not disturb it.
        rd_val = 12'o0456;
        push(1'b0, 15'o70103, 1'b0, 12'o0011, 12'o0104, 3'o7, 3'o0, 12'o0456, 1'b0);
        pulse(M_EXAM, 12'o0000);
        run = 1'b1;
        wait_idle("run_mid");
        run = 1'b0;
        ack_wait = 0;

        // 6: reset one cycle after DEP accept aborts; a late ack is ignored.
        ack_en = 1'b0;
        push(1'b0, 15'o00000, 1'b0, 12'o0000, 12'o0000, 3'o0, 3'o0, 12'o0000, 1'b0);
        pulse(M_DEP, 12'o3333);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_abort_req", 32'(mem_req), 32'd0);
        check("rst_abort_pc", 32'(pc), 32'o0);
        check("rst_abort_state", 32'(dbg_state), 32'(ST_IDLE));
        force_ack = 1'b1;
        @(posedge clk); #1;
        force_ack = 1'b0;
        check("late_ack_mb", 32'(mb), 32'o0);
        check("late_ack_pc", 32'(pc), 32'o0);
        check("late_ack_busy", 32'({busy, mem_req}), 32'd0);
        ack_en = 1'b1;

        push(1'b0, 15'o00000, 1'b1, 12'o0777, 12'o0001, 3'o0, 3'o0, 12'o0777, 1'b0);
        pulse(M_DEP, 12'o0777);
        wait_idle("dep_final");

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
